// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port memory between an instruction fetch
//               port and a data port, with a wait-state timeout abort.
//               Define MEM_ARB_RR_EN for alternating grants under contention;
//               otherwise the data port has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   // instruction fetch port
   input  logic        inst_ce_i,
   input  logic [31:0] inst_addr_i,
   output logic [31:0] inst_o,
   output logic        inst_ack_o,
   // data port
   input  logic        data_ce_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_sel_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        data_ack_o,
   // memory port
   output logic        mem_ce_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_sel_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   // status
   output logic        stallreq_o,
   output logic        bus_err_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_INST = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  r_state;
   logic [1:0]  w_next_state;

   logic        r_we;
   logic [3:0]  r_sel;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [7:0]  r_cnt;

   logic        r_inst_ack;
   logic        r_data_ack;
   logic        r_bus_err;
   logic [31:0] r_inst;
   logic [31:0] r_data_rdata;

   logic        w_busy;
   logic        w_done;
   logic        w_abort;
   logic        w_arb_open;
   logic        w_inst_req;
   logic        w_data_req;
   logic        w_grant_inst;
   logic        w_grant_data;

   // No grant while a completion pulse is still visible: the acked requester
   // has not yet had a chance to drop ce, so granting anyone here would let a
   // stale request race the one-cycle turnaround.
   assign w_arb_open = (r_state == S_IDLE) & ~r_inst_ack & ~r_data_ack;
   assign w_inst_req = inst_ce_i & w_arb_open;
   assign w_data_req = data_ce_i & w_arb_open;

`ifdef MEM_ARB_RR_EN
   logic r_last_data;

   always_comb begin
      w_grant_data = w_data_req & (~w_inst_req | ~r_last_data);
      w_grant_inst = w_inst_req & ~w_grant_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_data <= 1'b0;
      end else if (w_grant_data) begin
         r_last_data <= 1'b1;
      end else if (w_grant_inst) begin
         r_last_data <= 1'b0;
      end
   end
`else
   always_comb begin
      w_grant_data = w_data_req;
      w_grant_inst = w_inst_req & ~w_data_req;
   end
`endif

   assign w_busy  = (r_state != S_IDLE);
   assign w_done  = w_busy & mem_ack_i;
   assign w_abort = w_busy & ~mem_ack_i & (r_cnt == C_TMO_LAST);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant_data) begin
               w_next_state = S_DATA;
            end else if (w_grant_inst) begin
               w_next_state = S_INST;
            end
         end
         S_INST, S_DATA: begin
            if (w_done | w_abort) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      mem_ce_o = 1'b0;
      mem_we_o = 1'b0;
      case (r_state)
         S_INST, S_DATA: begin
            mem_ce_o = 1'b1;
            mem_we_o = r_we;
         end
         default: begin
            mem_ce_o = 1'b0;
            mem_we_o = 1'b0;
         end
      endcase
   end

   // ---------------- transaction fields, counter, completions ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we         <= 1'b0;
         r_sel        <= 4'h0;
         r_addr       <= 32'h0;
         r_wdata      <= 32'h0;
         r_cnt        <= 8'h0;
         r_inst_ack   <= 1'b0;
         r_data_ack   <= 1'b0;
         r_bus_err    <= 1'b0;
         r_inst       <= 32'h0;
         r_data_rdata <= 32'h0;
      end else begin
         r_inst_ack <= 1'b0;
         r_data_ack <= 1'b0;
         r_bus_err  <= 1'b0;

         if (w_grant_data) begin
            r_we    <= data_we_i;
            r_sel   <= data_sel_i;
            r_addr  <= data_addr_i;
            r_wdata <= data_wdata_i;
            r_cnt   <= 8'h0;
         end else if (w_grant_inst) begin
            r_we    <= 1'b0;
            r_sel   <= 4'hF;
            r_addr  <= inst_addr_i;
            r_wdata <= 32'h0;
            r_cnt   <= 8'h0;
         end else if (w_busy & ~w_done & ~w_abort) begin
            r_cnt <= r_cnt + 8'h1;
         end

         // An aborted read returns zero data alongside the ack
         if (w_done | w_abort) begin
            r_bus_err <= w_abort;
            if (r_state == S_INST) begin
               r_inst_ack <= 1'b1;
               r_inst     <= w_done ? mem_rdata_i : 32'h0;
            end else begin
               r_data_ack <= 1'b1;
               if (!r_we) begin
                  r_data_rdata <= w_done ? mem_rdata_i : 32'h0;
               end
            end
         end
      end
   end

   assign mem_sel_o    = r_sel;
   assign mem_addr_o   = r_addr;
   assign mem_wdata_o  = r_wdata;
   assign inst_o       = r_inst;
   assign inst_ack_o   = r_inst_ack;
   assign data_rdata_o = r_data_rdata;
   assign data_ack_o   = r_data_ack;
   assign bus_err_o    = r_bus_err;

   assign stallreq_o = (inst_ce_i & ~r_inst_ack) | (data_ce_i & ~r_data_ack);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (fetch, data
//               write/read, contention, timeout, reset abandon, MEM_ARB_RR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_ce_i;
   logic [31:0] inst_addr_i;
   logic [31:0] inst_o;
   logic        inst_ack_o;
   logic        data_ce_i;
   logic        data_we_i;
   logic [3:0]  data_sel_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic [31:0] data_rdata_o;
   logic        data_ack_o;
   logic        mem_ce_o;
   logic        mem_we_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;
   logic        stallreq_o;
   logic        bus_err_o;

   int n_checks = 0;
   int n_pass   = 0;

   mem_arbiter #(.TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .inst_ce_i    (inst_ce_i),
      .inst_addr_i  (inst_addr_i),
      .inst_o       (inst_o),
      .inst_ack_o   (inst_ack_o),
      .data_ce_i    (data_ce_i),
      .data_we_i    (data_we_i),
      .data_sel_i   (data_sel_i),
      .data_addr_i  (data_addr_i),
      .data_wdata_i (data_wdata_i),
      .data_rdata_o (data_rdata_o),
      .data_ack_o   (data_ack_o),
      .mem_ce_o     (mem_ce_o),
      .mem_we_o     (mem_we_o),
      .mem_sel_o    (mem_sel_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i),
      .mem_ack_i    (mem_ack_i),
      .stallreq_o   (stallreq_o),
      .bus_err_o    (bus_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      int          n_grants;
      logic [31:0] owners [4];
      logic [31:0] exp_owner;

      rst          = 1'b1;
      inst_ce_i    = 1'b0;
      inst_addr_i  = 32'h0;
      data_ce_i    = 1'b0;
      data_we_i    = 1'b0;
      data_sel_i   = 4'h0;
      data_addr_i  = 32'h0;
      data_wdata_i = 32'h0;
      mem_rdata_i  = 32'h0;
      mem_ack_i    = 1'b0;
      tick();
      tick();

      // reset state
      check("rst_mem_ce",   {31'h0, mem_ce_o},   32'h0);
      check("rst_mem_we",   {31'h0, mem_we_o},   32'h0);
      check("rst_mem_sel",  {28'h0, mem_sel_o},  32'h0);
      check("rst_mem_addr", mem_addr_o,          32'h0);
      check("rst_inst_o",   inst_o,              32'h0);
      check("rst_rdata",    data_rdata_o,        32'h0);
      check("rst_acks",     {30'h0, inst_ack_o, data_ack_o}, 32'h0);
      check("rst_bus_err",  {31'h0, bus_err_o},  32'h0);
      rst = 1'b0;
      tick();

      // fetch only, minimum latency
      inst_ce_i   = 1'b1;
      inst_addr_i = 32'h0000_0010;
      tick();
      check("f_mem_ce",   {31'h0, mem_ce_o},  32'h1);
      check("f_mem_addr", mem_addr_o,         32'h0000_0010);
      check("f_mem_we",   {31'h0, mem_we_o},  32'h0);
      check("f_mem_sel",  {28'h0, mem_sel_o}, 32'hF);
      check("f_stall",    {31'h0, stallreq_o}, 32'h1);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h3C01_0101;
      tick();
      check("f_ack",      {31'h0, inst_ack_o}, 32'h1);
      check("f_inst_o",   inst_o,              32'h3C01_0101);
      check("f_stall_ak", {31'h0, stallreq_o}, 32'h0);
      check("f_ce_idle",  {31'h0, mem_ce_o},   32'h0);
      inst_ce_i = 1'b0;
      mem_ack_i = 1'b0;
      tick();
      check("f_ack_pulse", {31'h0, inst_ack_o}, 32'h0);
      check("f_inst_hold", inst_o,              32'h3C01_0101);

      // simultaneous requests: data write first, then fetch
      data_ce_i    = 1'b1;
      data_we_i    = 1'b1;
      data_sel_i   = 4'hF;
      data_addr_i  = 32'h0000_0100;
      data_wdata_i = 32'hDEAD_BEEF;
      inst_ce_i    = 1'b1;
      inst_addr_i  = 32'h0000_0020;
      tick();
      check("s_mem_we",    {31'h0, mem_we_o},   32'h1);
      check("s_mem_addr",  mem_addr_o,          32'h0000_0100);
      check("s_mem_wdata", mem_wdata_o,         32'hDEAD_BEEF);
      data_addr_i = 32'h0000_0F00;  // mid-grant change must not show
      tick();
      check("s_addr_held", mem_addr_o,          32'h0000_0100);
      check("s_stall",     {31'h0, stallreq_o}, 32'h1);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h1234_5678;
      tick();
      check("s_data_ack",  {31'h0, data_ack_o}, 32'h1);
      check("s_no_iack",   {31'h0, inst_ack_o}, 32'h0);
      check("s_wr_rdata",  data_rdata_o,        32'h0);
      check("s_stall_i",   {31'h0, stallreq_o}, 32'h1);
      data_ce_i = 1'b0;
      mem_ack_i = 1'b0;
      tick();
      check("s_turn_ce",   {31'h0, mem_ce_o},   32'h0);
      tick();
      check("s_i_ce",      {31'h0, mem_ce_o},   32'h1);
      check("s_i_addr",    mem_addr_o,          32'h0000_0020);
      check("s_i_we",      {31'h0, mem_we_o},   32'h0);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hCAFE_F00D;
      tick();
      check("s_i_ack",     {31'h0, inst_ack_o}, 32'h1);
      check("s_i_data",    inst_o,              32'hCAFE_F00D);
      inst_ce_i = 1'b0;
      mem_ack_i = 1'b0;
      tick();

      // data read
      data_ce_i   = 1'b1;
      data_we_i   = 1'b0;
      data_sel_i  = 4'h3;
      data_addr_i = 32'h0000_0200;
      tick();
      check("r_mem_we",  {31'h0, mem_we_o},  32'h0);
      check("r_mem_sel", {28'h0, mem_sel_o}, 32'h3);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hA5A5_5A5A;
      tick();
      check("r_ack",     {31'h0, data_ack_o}, 32'h1);
      check("r_rdata",   data_rdata_o,        32'hA5A5_5A5A);
      check("r_inst_h",  inst_o,              32'hCAFE_F00D);
      data_ce_i = 1'b0;
      tick();

      // mem_ack_i while idle is ignored
      tick();
      check("i_acks", {30'h0, inst_ack_o, data_ack_o}, 32'h0);
      check("i_ce",   {31'h0, mem_ce_o},              32'h0);
      mem_ack_i = 1'b0;

      // timeout on a fetch: 16 granted cycles, then abort
      inst_ce_i   = 1'b1;
      inst_addr_i = 32'h0000_0040;
      tick();
      for (int i = 0; i < 15; i++) begin
         tick();
         check("t_busy", {30'h0, mem_ce_o, bus_err_o}, 32'h2);
      end
      tick();
      check("t_bus_err", {31'h0, bus_err_o},  32'h1);
      check("t_ack",     {31'h0, inst_ack_o}, 32'h1);
      check("t_inst_0",  inst_o,              32'h0);
      check("t_idle",    {31'h0, mem_ce_o},   32'h0);
      inst_ce_i = 1'b0;
      tick();
      check("t_err_pls", {31'h0, bus_err_o},  32'h0);

      // reset during a data grant
      data_ce_i    = 1'b1;
      data_we_i    = 1'b1;
      data_sel_i   = 4'hC;
      data_addr_i  = 32'h0000_0300;
      data_wdata_i = 32'h0000_0001;
      tick();
      check("x_busy", {31'h0, mem_ce_o}, 32'h1);
      rst       = 1'b1;
      mem_ack_i = 1'b1;
      tick();
      check("x_ce",     {31'h0, mem_ce_o},   32'h0);
      check("x_no_ack", {31'h0, data_ack_o}, 32'h0);
      check("x_fields", {mem_sel_o, mem_addr_o[27:0]} | mem_wdata_o, 32'h0);
      check("x_rdata",  data_rdata_o,        32'h0);
      check("x_stall",  {31'h0, stallreq_o}, 32'h1);
      rst       = 1'b0;
      mem_ack_i = 1'b0;
      data_ce_i = 1'b0;
      tick();

      // both requesters held, memory always acknowledging
      data_ce_i   = 1'b1;
      data_we_i   = 1'b0;
      data_addr_i = 32'h0000_0500;
      inst_ce_i   = 1'b1;
      inst_addr_i = 32'h0000_0600;
      mem_ack_i   = 1'b1;
      n_grants    = 0;
      for (int cyc = 0; cyc < 40 && n_grants < 4; cyc++) begin
         tick();
         if (mem_ce_o) begin
            owners[n_grants] = mem_addr_o;
            n_grants++;
         end
      end
      check("c_grants", n_grants, 32'd4);
      for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
         exp_owner = (i % 2 == 0) ? 32'h0000_0500 : 32'h0000_0600;
`else
         exp_owner = 32'h0000_0500;
`endif
         check("c_owner", owners[i], exp_owner);
      end
      data_ce_i = 1'b0;
      inst_ce_i = 1'b0;
      mem_ack_i = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, cycles granted without mem_ack_i before abort (range 2..255).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have fetch ports: inst_ce_i in 1 request; inst_addr_i in 32; inst_o out 32 read data; inst_ack_o out 1 completion pulse.
REQ-005 SHALL have data ports: data_ce_i in 1; data_we_i in 1; data_sel_i in 4 byte enables; data_addr_i in 32; data_wdata_i in 32; data_rdata_o out 32; data_ack_o out 1.
REQ-006 SHALL have memory ports: mem_ce_o out 1; mem_we_o out 1; mem_sel_o out 4; mem_addr_o out 32; mem_wdata_o out 32; mem_rdata_i in 32; mem_ack_i in 1.
REQ-007 SHALL have status ports: stallreq_o out 1 pipeline stall; bus_err_o out 1 timeout pulse.

Function
REQ-008 SHALL implement FSM states IDLE, INST, DATA; shares one single-port memory between fetch and data requesters.
REQ-009 IDLE: data_ce_i wins over inst_ce_i (fixed priority); chosen request's addr/we/sel/wdata SHALL be registered on the grant edge; fetch grant forces we=0, sel=4'hF.
REQ-010 In INST/DATA: mem_ce_o=1 and mem_* driven from registered fields; in IDLE mem_ce_o=0, mem_we_o=0.
REQ-011 On mem_ack_i in INST/DATA: next edge SHALL load mem_rdata_i into inst_o or data_rdata_o, pulse matching ack for exactly one cycle, return to IDLE.
REQ-012 Minimum latency: request seen in IDLE at edge N, mem_ce_o high cycle N+1, ack at N+2 if mem_ack_i in cycle N+1.
REQ-013 Requesters SHALL hold ce and fields until their ack; in IDLE a requester whose ack_o is currently high SHALL be masked from arbitration (no duplicate grant).
REQ-014 inst_o/data_rdata_o SHALL hold last value until next completion for that port; writes leave data_rdata_o unchanged.
REQ-015 stallreq_o = (inst_ce_i & ~inst_ack_o) | (data_ce_i & ~data_ack_o), combinational.
REQ-016 8-bit wait counter SHALL clear on grant, increment each granted cycle without mem_ack_i; at TIMEOUT-1 with no ack, SHALL abort: return IDLE, pulse owner's ack with read data 0, pulse bus_err_o one cycle.
REQ-017 mem_ack_i in IDLE SHALL be ignored.
REQ-018 Request inputs changing mid-grant SHALL not affect mem_* outputs.

Reset
REQ-019 While rst=1 at an edge: state IDLE; mem_ce_o, mem_we_o, inst_ack_o, data_ack_o, bus_err_o =0; mem_sel_o, mem_addr_o, mem_wdata_o, inst_o, data_rdata_o =0; counter 0.
REQ-020 Reset mid-transaction SHALL abandon it without any ack pulse; stallreq_o follows REQ-015 after reset.

Configuration
REQ-021 With MEM_ARB_RR_EN defined: 1-bit last-owner register (reset: INST) SHALL grant, when both request in IDLE, the port not granted last; single requests granted as usual.
REQ-022 Without MEM_ARB_RR_EN: fixed data priority per REQ-009; no last-owner register.

Verification
REQ-023 Fetch only: inst_ce_i=1, addr 0x00000010, mem_ack_i one cycle after mem_ce_o, rdata 0x3C010101 -> inst_o=0x3C010101, inst_ack_o one-cycle pulse, latency 2 cycles.
REQ-024 Simultaneous requests, data write addr 0x100 wdata 0xDEADBEEF sel 4'hF -> mem_we_o=1 first, data_ack_o, then fetch granted; inst_ack_o after; stallreq_o high until each ack.
REQ-025 Timeout, TIMEOUT=16, mem_ack_i stuck 0 -> after 16 granted cycles bus_err_o and owner ack pulse, rdata 0, state IDLE.
REQ-026 rst asserted during DATA grant -> next edge mem_ce_o=0, no data_ack_o pulse, all outputs at reset values.
REQ-027 MEM_ARB_RR_EN defined, both ce held high, mem_ack_i always 1 -> grants alternate DATA, INST, DATA, INST; undefined -> DATA repeatedly after each ack while data_ce_i remains high.
